// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction-fetch front end for the 16-bit five-stage core. It owns the fetch
// PC, issues word-addressed reads to instruction memory (one outstanding at a
// time), buffers returned words tagged with PC+1 in a small FIFO, and presents
// the FIFO head to the IF/ID pipeline register.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous assert, active-low reset, synchronous release
//   imem_req        read request strobe, one cycle per request (registered)
//   imem_addr       word address of the request, valid while imem_req=1
//   imem_rvalid     response strobe, 1..N cycles after imem_req
//   imem_rdata      instruction word, valid with imem_rvalid
//   redirect        flush and refetch (branch/JAL/JR/EXEC resolved in EX/MEM)
//   redirect_target new fetch address, valid with redirect
//   dec_ready       decode accepts the head entry this cycle
//   inst_valid      FIFO head is valid
//   inst            head instruction
//   inst_pc_added   head entry's PC+1 (mod 2^16)
//   q_count         current FIFO occupancy
//   dbg_state       fetch FSM state (0=IDLE, 1=WAIT, 2=STALE)
//
// Handshakes
//   Decode side: an entry transfers on a cycle where inst_valid=1 and
//   dec_ready=1 (and no redirect). inst/inst_pc_added are stable while
//   inst_valid=1 and dec_ready=0. dec_ready while empty has no effect.
//   Memory side: imem_req is a single-cycle strobe; exactly one imem_rvalid
//   pulse answers each request. No new request is issued until that pulse has
//   been seen, so responses never need an ID.
// -----------------------------------------------------------------------------
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [15:0]            imem_addr,
  input  logic                   imem_rvalid,
  input  logic [15:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [15:0]            redirect_target,
  input  logic                   dec_ready,
  output logic                   inst_valid,
  output logic [15:0]            inst,
  output logic [15:0]            inst_pc_added,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // IDLE : nothing outstanding
  // WAIT : one request outstanding, its data will be queued
  // STALE: one request outstanding, its data will be thrown away (redirected)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STALE = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   mem_inst [DEPTH];
  logic [15:0]   mem_pc   [DEPTH];

  logic          push;
  logic          pop;
  logic          issue;
  logic [CW-1:0] occ_next;

  // ---------------------------------------------------------------------------
  // Per-cycle decisions (redirect overrides all of them)
  // ---------------------------------------------------------------------------
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    issue    = 1'b0;
    occ_next = count;

    push     = (state == S_WAIT) && imem_rvalid && !redirect;
    pop      = (count != '0) && dec_ready && !redirect;
    occ_next = count + CW'(push) - CW'(pop);

    // A response arriving in WAIT frees the single outstanding slot, so the
    // next request can be launched in that same cycle; this is what gives one
    // instruction every two cycles with a 1-cycle memory. occ_next already
    // counts the word being pushed, so a free slot is guaranteed for the
    // request being launched.
    issue    = !redirect && ((state == S_IDLE) || push) &&
               (occ_next < CW'(DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM, fetch PC, request registers and FIFO storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // Flush: everything queued belongs to the wrong path.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (state == S_IDLE) begin
        // Nothing in flight, so the target can be requested straight away;
        // the request appears on the port the cycle after the redirect.
        imem_req  <= 1'b1;
        imem_addr <= redirect_target;
        req_pc    <= redirect_target;
        fetch_pc  <= redirect_target + 16'd1;
        state     <= S_WAIT;
      end else begin
        // A request is in flight. If its response is here now it is dropped
        // and the request is complete; otherwise its data is still owed and
        // must be discarded when it arrives.
        imem_req <= 1'b0;
        fetch_pc <= redirect_target;
        state    <= imem_rvalid ? S_IDLE : S_STALE;
      end
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]   <= req_pc + 16'd1;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= occ_next;
      imem_req <= issue;
      if (issue) begin
        imem_addr <= fetch_pc;
        req_pc    <= fetch_pc;
        fetch_pc  <= fetch_pc + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (issue) state <= S_WAIT;
        end
        S_WAIT: begin
          // On a response either a new request is launched (stay in WAIT)
          // or the FIFO is too full and we rest in IDLE.
          if (imem_rvalid && !issue) state <= S_IDLE;
        end
        S_STALE: begin
          // Wrong-path data is discarded; no request in this cycle.
          if (imem_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head of the FIFO, straight from storage registers
  // ---------------------------------------------------------------------------
  assign inst_valid    = (count != '0);
  assign inst          = mem_inst[rd_ptr];
  assign inst_pc_added = mem_pc[rd_ptr];
  assign q_count       = count;
  assign dbg_state     = state;

  // The issue rule reserves a slot for every in-flight word, so a push can
  // never land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == CW'(DEPTH))));

endmodule
